// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, shared by the ALU and LSU.
// It also keeps a busy scoreboard of destination registers that have a write still pending.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,

    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,

    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,

    output logic        RegWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic [31:0] busy_mask
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e      last_grant;
    logic        alu_grant;
    logic        lsu_grant;
    logic        xfer;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_data;
    logic [31:0] busy_next;

    // Round-robin grant: a lone requester wins at once; on a tie, whoever lost last time wins.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            if (alu_valid && lsu_valid) begin
                if (last_grant == GRANT_LSU) begin
                    alu_grant = 1'b1;
                end else begin
                    lsu_grant = 1'b1;
                end
            end else begin
                alu_grant = alu_valid;
                lsu_grant = lsu_valid;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign lsu_ready = lsu_grant;
    assign xfer      = alu_grant | lsu_grant;
    assign xfer_rd   = lsu_grant ? lsu_rd   : alu_rd;
    assign xfer_data = lsu_grant ? lsu_data : alu_data;

    // Clear is applied before set so an issue on the same edge as a retiring write keeps the bit.
    always_comb begin
        busy_next = busy_mask;
        if (xfer) begin
            busy_next[xfer_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            writeReg   <= 5'd0;
            writeData  <= 32'd0;
            busy_mask  <= 32'd0;
            last_grant <= GRANT_LSU;
        end else begin
            // Writes to x0 complete the handshake but never reach the register file.
            RegWrite  <= xfer && (xfer_rd != 5'd0);
            busy_mask <= busy_next;
            if (xfer) begin
                writeReg   <= xfer_rd;
                writeData  <= xfer_data;
                last_grant <= lsu_grant ? GRANT_LSU : GRANT_ALU;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake latency, round-robin order,
// scoreboard set/clear and mid-transfer reset, all against hand-computed values.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] busy_mask;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .RegWrite    (RegWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .busy_mask   (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #3;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic        alu_wins;
        logic [31:0] na;
        logic [31:0] nl;

        reset    = 1'b1;
        alu_rd   = 5'd0;
        alu_data = 32'd0;
        lsu_rd   = 5'd0;
        lsu_data = 32'd0;
        issue_rd = 5'd0;
        idle_inputs();

        // Reset state, and no grant while reset is held even with requests present.
        step();
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        #1;
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        check("rst_regwrite",  {31'd0, RegWrite},  32'd0);
        check("rst_writereg",  {27'd0, writeReg},  32'd0);
        check("rst_writedata", writeData,          32'd0);
        check("rst_busy",      busy_mask,          32'd0);
        idle_inputs();
        step();
        reset = 1'b0;

        // Lone ALU request: granted the same cycle, written the next, gone after.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        #1;
        check("single_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("single_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        step();
        alu_valid = 1'b0;
        check("single_regwrite",  {31'd0, RegWrite}, 32'd1);
        check("single_writereg",  {27'd0, writeReg}, 32'd5);
        check("single_writedata", writeData,         32'hDEAD_BEEF);
        step();
        check("single_regwrite_off", {31'd0, RegWrite}, 32'd0);
        check("single_writereg_hold", {27'd0, writeReg}, 32'd5);
        check("single_writedata_hold", writeData,        32'hDEAD_BEEF);

        // Both requesters valid back to back: ALU, LSU, ALU, LSU with no bubble.
        pulse_reset();
        na = 32'd0;
        nl = 32'd0;
        alu_rd    = 5'd1;
        lsu_rd    = 5'd2;
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'hA000_0000 + na;
            lsu_data = 32'hB000_0000 + nl;
            #1;
            alu_wins = (i % 2 == 0);
            check($sformatf("rr%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, alu_wins});
            check($sformatf("rr%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, !alu_wins});
            step();
            check($sformatf("rr%0d_regwrite", i), {31'd0, RegWrite}, 32'd1);
            check($sformatf("rr%0d_writereg", i), {27'd0, writeReg}, alu_wins ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_writedata", i), writeData,
                  alu_wins ? (32'hA000_0000 + na) : (32'hB000_0000 + nl));
            if (alu_wins) na = na + 1;
            else          nl = nl + 1;
        end
        idle_inputs();
        step();
        check("rr_regwrite_off", {31'd0, RegWrite}, 32'd0);

        // Scoreboard: issue sets bit 7, LSU writeback to r7 clears it.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        check("busy_set7", busy_mask, 32'h0000_0080);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h0000_0777;
        #1;
        check("clr7_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        lsu_valid = 1'b0;
        check("busy_clr7",      busy_mask,         32'd0);
        check("clr7_regwrite",  {31'd0, RegWrite}, 32'd1);
        check("clr7_writereg",  {27'd0, writeReg}, 32'd7);
        check("clr7_writedata", writeData,         32'h0000_0777);

        // Issue to r0 never marks it busy.
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        step();
        issue_valid = 1'b0;
        check("busy_r0_issue", busy_mask, 32'd0);

        // Bit 9 set, re-issued while busy, then issue and writeback on one edge: set wins.
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        check("busy_set9", busy_mask, 32'h0000_0200);
        step();
        check("busy_reissue9", busy_mask, 32'h0000_0200);
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h0000_0099;
        #1;
        check("same9_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        idle_inputs();
        check("same9_busy",      busy_mask,         32'h0000_0200);
        check("same9_regwrite",  {31'd0, RegWrite}, 32'd1);
        check("same9_writereg",  {27'd0, writeReg}, 32'd9);
        check("same9_writedata", writeData,         32'h0000_0099);

        // ALU write to r0: handshake completes, no register write, pointer still moves.
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h0000_1234;
        #1;
        check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        check("x0_regwrite", {31'd0, RegWrite}, 32'd0);
        check("x0_busy",     busy_mask,         32'h0000_0200);
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0000_0033;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'h0000_0044;
        #1;
        check("x0_tie_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("x0_tie_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        step();
        lsu_valid = 1'b0;
        check("x0_tie_writereg", {27'd0, writeReg}, 32'd4);
        check("x0_tie_regwrite", {31'd0, RegWrite}, 32'd1);

        // ALU (still requesting) wins as a lone requester; reset lands before the write cycle ends.
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        #1;
        check("mid_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        idle_inputs();
        check("mid_busy_before", busy_mask, 32'h0000_1200);
        #2;
        reset     = 1'b1;
        alu_valid = 1'b1;
        #1;
        check("mid_regwrite",  {31'd0, RegWrite},  32'd0);
        check("mid_writereg",  {27'd0, writeReg},  32'd0);
        check("mid_busy",      busy_mask,          32'd0);
        check("mid_alu_ready_rst", {31'd0, alu_ready}, 32'd0);
        step();
        reset     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0000_0333;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd4;
        lsu_data  = 32'h0000_0444;
        #1;
        check("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
        step();
        idle_inputs();
        check("post_rst_writereg",  {27'd0, writeReg}, 32'd3);
        check("post_rst_writedata", writeData,         32'h0000_0333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
